// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: registers operands, holds them for a
// per-opcode settling window, then captures RZ. Optional ALU_OP_SEQUENCER_STATS_EN adds op_count.
module alu_op_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter logic [4:0]  MUL_OP        = 5'b01111,
  parameter logic [4:0]  DIV_OP        = 5'b10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_ra,
  output logic [31:0] alu_rb,
  output logic [4:0]  alu_opcode,
  input  logic [63:0] alu_rz,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
`ifdef ALU_OP_SEQUENCER_STATS_EN
  output logic [15:0] op_count,
`endif
  output logic        busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_muldiv;
  logic               div_by_zero;

  assign is_muldiv   = (req_opcode == MUL_OP) || (req_opcode == DIV_OP);
  assign div_by_zero = (req_opcode == DIV_OP) && (req_b == 32'd0);

  // Main sequencer; all handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_ra     <= '0;
      alu_rb     <= '0;
      alu_opcode <= '0;
      rsp_lo     <= '0;
      rsp_hi     <= '0;
      rsp_err    <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_opcode <= req_opcode;
            alu_ra     <= req_a;
            alu_rb     <= req_b;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            if (div_by_zero) begin
              rsp_lo    <= '0;
              rsp_hi    <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt   <= is_muldiv ? CNT_W'(MULDIV_CYCLES - 1) : '0;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_lo    <= alu_rz[31:0];
            rsp_hi    <= alu_rz[63:32];
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_OP_SEQUENCER_STATS_EN
  // Saturating count of response handshakes, error responses included.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a small behavioural ALU.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam logic [4:0] MUL_OP = 5'b01111;
  localparam logic [4:0] DIV_OP = 5'b10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_ra, alu_rb;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_rz;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_err;
  logic        busy;
`ifdef ALU_OP_SEQUENCER_STATS_EN
  logic [15:0] op_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.MULDIV_CYCLES(4), .MUL_OP(MUL_OP), .DIV_OP(DIV_OP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_opcode(alu_opcode), .alu_rz(alu_rz),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err),
`ifdef ALU_OP_SEQUENCER_STATS_EN
    .op_count(op_count),
`endif
    .busy(busy)
  );

  // Behavioural ALU: add, sub, signed multiply, divide (lo=quotient, hi=remainder), else xor.
  logic signed [63:0] sa, sb;
  always_comb begin
    sa = {{32{alu_ra[31]}}, alu_ra};
    sb = {{32{alu_rb[31]}}, alu_rb};
    case (alu_opcode)
      5'b00000: alu_rz = {32'd0, alu_ra + alu_rb};
      5'b00010: alu_rz = {32'd0, alu_ra - alu_rb};
      MUL_OP:   alu_rz = sa * sb;
      DIV_OP:   alu_rz = (alu_rb == 32'd0) ? 64'd0 : {alu_ra % alu_rb, alu_ra / alu_rb};
      default:  alu_rz = {32'd0, alu_ra ^ alu_rb};
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_ra", 64'(alu_ra), 64'd0);
    check("rst_rsp_lo", 64'(rsp_lo), 64'd0);
`ifdef ALU_OP_SEQUENCER_STATS_EN
    check("rst_op_count", 64'(op_count), 64'd0);
`endif

    // Single-cycle add
    rsp_ready = 1'b1;
    present(5'b00000, 32'd8, 32'd8);
    tick();
    req_valid = 1'b0;
    check("add_alu_ra", 64'(alu_ra), 64'd8);
    check("add_busy", 64'(busy), 64'd1);
    check("add_req_ready_n", 64'(req_ready), 64'd0);
    check("add_valid_n", 64'(rsp_valid), 64'd0);
    tick();
    check("add_valid", 64'(rsp_valid), 64'd1);
    check("add_lo", 64'(rsp_lo), 64'd16);
    check("add_hi", 64'(rsp_hi), 64'd0);
    check("add_err", 64'(rsp_err), 64'd0);
    tick();
    check("add_idle_valid", 64'(rsp_valid), 64'd0);
    check("add_idle_ready", 64'(req_ready), 64'd1);

    // Multi-cycle multiply
    rsp_ready = 1'b0;
    present(MUL_OP, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mul_wait_valid", 64'(rsp_valid), 64'd0);
      check("mul_wait_busy", 64'(busy), 64'd1);
      check("mul_wait_ready", 64'(req_ready), 64'd0);
      tick();
    end
    check("mul_pre_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("mul_valid", 64'(rsp_valid), 64'd1);
    check("mul_rz", {rsp_hi, rsp_lo}, 64'd64);
    check("mul_done_busy", 64'(busy), 64'd1);
    rsp_ready = 1'b1;
    tick();
    check("mul_idle", 64'(req_ready), 64'd1);

    // Divide by zero takes the error path with no wait
    present(DIV_OP, 32'd36, 32'd0);
    tick();
    req_valid = 1'b0;
    check("dz_valid", 64'(rsp_valid), 64'd1);
    check("dz_err", 64'(rsp_err), 64'd1);
    check("dz_rz", {rsp_hi, rsp_lo}, 64'd0);
    tick();
    check("dz_idle", 64'(req_ready), 64'd1);

    present(DIV_OP, 32'd36, 32'd6);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    check("div_pre_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("div_valid", 64'(rsp_valid), 64'd1);
    check("div_lo", 64'(rsp_lo), 64'd6);
    check("div_hi", 64'(rsp_hi), 64'd0);
    check("div_err", 64'(rsp_err), 64'd0);
    tick();

    // Backpressure with a second request waiting
    rsp_ready = 1'b0;
    present(5'b00010, 32'd16, 32'd8);
    tick();
    present(5'b00000, 32'd1, 32'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_lo", 64'(rsp_lo), 64'd8);
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_alu_ra", 64'(alu_ra), 64'd16);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_hs_valid", 64'(rsp_valid), 64'd0);
    check("bp_hs_ready", 64'(req_ready), 64'd1);
    check("bp_hs_alu_ra", 64'(alu_ra), 64'd16);
    tick();
    req_valid = 1'b0;
    check("bp_acc_alu_ra", 64'(alu_ra), 64'd1);
    check("bp_acc_busy", 64'(busy), 64'd1);
    tick();
    check("bp2_valid", 64'(rsp_valid), 64'd1);
    check("bp2_lo", 64'(rsp_lo), 64'd3);
    tick();

    // Reset during the second EXEC cycle of a multiply
    present(MUL_OP, 32'd3, 32'd5);
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ra_ready", 64'(req_ready), 64'd1);
    check("ra_busy", 64'(busy), 64'd0);
    check("ra_valid", 64'(rsp_valid), 64'd0);
    check("ra_alu", {27'd0, alu_opcode, alu_ra}, 64'd0);
    check("ra_rsp", {rsp_hi, rsp_lo}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      check("ra_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end

`ifdef ALU_OP_SEQUENCER_STATS_EN
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      present(5'b00000, 32'(i), 32'd1);
      tick();
      req_valid = 1'b0;
      tick(); tick();
    end
    check("st_count3", 64'(op_count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("st_count_rst", 64'(op_count), 64'd0);
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    for (int i = 0; i < 3; i++) begin
      present(5'b00000, 32'd1, 32'd1);
      tick();
      req_valid = 1'b0;
      tick(); tick();
    end
    check("st_sat", 64'(op_count), 64'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
